// File: rtl/vga_line_fetch.sv
// vga_line_fetch: fetches one video line from word-addressed memory in
// fixed-length bursts and streams the returned beats into line buffer A or B.
// A line is 640 or 1024 words, chosen by vga_mode when the request arrives.
module vga_line_fetch #(
  parameter logic [23:0] FB_BASE   = 24'h000000,
  parameter int          BURST_LEN = 16
) (
  input  logic        vga_clk,
  input  logic        rst_n_w,
  input  logic        vga_mode,
  input  logic        read_buff_req,
  input  logic        read_buff_A_B,
  input  logic [9:0]  read_buff_addr,
  input  logic        clear_err,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        buffA_wr_en,
  output logic        buffB_wr_en,
  output logic [9:0]  buff_wr_addr,
  output logic [15:0] buff_wr_data,
  output logic        fetch_busy,
  output logic        underrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  localparam logic [6:0] BEAT_LAST = 7'(BURST_LEN - 1);

  // Word address of the first word of a line; shifts and adds only
  // (640 = 512 + 128), result wraps at 24 bits.
  function automatic logic [23:0] line_base(input logic [9:0] line, input logic mode);
    logic [23:0] l24;
    l24 = {14'd0, line};
    if (mode) begin
      line_base = FB_BASE + (l24 << 10);
    end else begin
      line_base = FB_BASE + (l24 << 9) + (l24 << 7);
    end
  endfunction

  state_t      state_q, state_d;
  logic        req_q;
  logic        req_rise_s;
  logic [9:0]  line_q, line_d;
  logic        ab_q, ab_d;
  logic        mode_q, mode_d;
  logic [10:0] word_idx_q, word_idx_d;
  logic [6:0]  beat_q, beat_d;
  logic [10:0] line_len_s;
  logic        mem_req_q, mem_req_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic        wra_q, wra_d;
  logic        wrb_q, wrb_d;
  logic [9:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        underrun_q, underrun_d;

  assign req_rise_s = read_buff_req & ~req_q;
  assign line_len_s = mode_q ? 11'd1024 : 11'd640;

  // Next-state, latched fetch parameters and registered-output values.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    ab_d       = ab_q;
    mode_d     = mode_q;
    word_idx_d = word_idx_q;
    beat_d     = beat_q;
    wra_d      = 1'b0;
    wrb_d      = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (req_rise_s) begin
          line_d     = read_buff_addr;
          ab_d       = read_buff_A_B;
          mode_d     = vga_mode;
          word_idx_d = 11'd0;
          beat_d     = 7'd0;
          state_d    = ST_ISSUE;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DATA: begin
        if (mem_rvalid) begin
          wra_d      = ~ab_q;
          wrb_d      = ab_q;
          wr_addr_d  = word_idx_q[9:0];
          wr_data_d  = mem_rdata;
          word_idx_d = word_idx_q + 11'd1;
          if (beat_q == BEAT_LAST) begin
            beat_d = 7'd0;
            if (word_idx_d == line_len_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_ISSUE;
            end
          end else begin
            beat_d = beat_q + 7'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Request and address are derived from the state being entered so they
    // appear together on the first ISSUE cycle and hold until the ack.
    mem_req_d = (state_d == ST_ISSUE);
    if (mem_req_d) begin
      mem_addr_d = line_base(line_d, mode_d) + {13'd0, word_idx_d};
    end else begin
      mem_addr_d = mem_addr_q;
    end

    // Busy stays high through the cycle carrying the final write strobe.
    busy_d = (state_d != ST_IDLE) || (state_q != ST_IDLE);

    // A new request while busy is dropped and flagged; set beats clear.
    if (req_rise_s && (state_q != ST_IDLE)) begin
      underrun_d = 1'b1;
    end else if (clear_err) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // State, fetch context and registered outputs.
  always_ff @(posedge vga_clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      line_q     <= 10'd0;
      ab_q       <= 1'b0;
      mode_q     <= 1'b0;
      word_idx_q <= 11'd0;
      beat_q     <= 7'd0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 24'd0;
      wra_q      <= 1'b0;
      wrb_q      <= 1'b0;
      wr_addr_q  <= 10'd0;
      wr_data_q  <= 16'd0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= read_buff_req;
      line_q     <= line_d;
      ab_q       <= ab_d;
      mode_q     <= mode_d;
      word_idx_q <= word_idx_d;
      beat_q     <= beat_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wra_q      <= wra_d;
      wrb_q      <= wrb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign buffA_wr_en  = wra_q;
  assign buffB_wr_en  = wrb_q;
  assign buff_wr_addr = wr_addr_q;
  assign buff_wr_data = wr_data_q;
  assign fetch_busy   = busy_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Self-checking bench for vga_line_fetch: a memory responder with random
// ack delay and beat gaps, and a line-level reference model that predicts
// every burst address and every line-buffer write.
module tb_vga_line_fetch;

  localparam int FB_BASE_TB = 0;
  localparam int BL         = 16;

  logic        vga_clk = 1'b0;
  logic        rst_n_w;
  logic        vga_mode;
  logic        read_buff_req;
  logic        read_buff_A_B;
  logic [9:0]  read_buff_addr;
  logic        clear_err;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        buffA_wr_en;
  logic        buffB_wr_en;
  logic [9:0]  buff_wr_addr;
  logic [15:0] buff_wr_data;
  logic        fetch_busy;
  logic        underrun;

  int n_cmp = 0;
  int n_bad = 0;

  // expected writes: {1=buffer B, addr[9:0], data[15:0]}
  logic [26:0] exp_q[$];
  logic [63:0] outs_all;

  assign outs_all = {9'd0, mem_req, mem_addr, buffA_wr_en, buffB_wr_en,
                     buff_wr_addr, buff_wr_data, fetch_busy, underrun};

  vga_line_fetch dut (
    .vga_clk        (vga_clk),
    .rst_n_w        (rst_n_w),
    .vga_mode       (vga_mode),
    .read_buff_req  (read_buff_req),
    .read_buff_A_B  (read_buff_A_B),
    .read_buff_addr (read_buff_addr),
    .clear_err      (clear_err),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .buffA_wr_en    (buffA_wr_en),
    .buffB_wr_en    (buffB_wr_en),
    .buff_wr_addr   (buff_wr_addr),
    .buff_wr_data   (buff_wr_data),
    .fetch_busy     (fetch_busy),
    .underrun       (underrun)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [15:0] mdata(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
  endfunction

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // Line-buffer write monitor against the expected-write queue.
  always @(negedge vga_clk) begin
    if (buffA_wr_en || buffB_wr_en) begin
      chk("one_hot_wr", 64'(buffA_wr_en & buffB_wr_en), 64'd0);
      if (exp_q.size() == 0) begin
        chk("spurious_wr", 64'({buffA_wr_en, buffB_wr_en}), 64'd0);
      end else begin
        chk("wr", 64'({buffB_wr_en, buff_wr_addr, buff_wr_data}), 64'(exp_q.pop_front()));
        chk("busy_on_wr", 64'(fetch_busy), 64'd1);
      end
    end
  end

  // One line fetch. mid_act: 0 none, 1 change inputs/drop req mid-fetch,
  // 2 extra request rises (underrun), 3 reset mid-DATA and abandon.
  task automatic do_fetch(input logic [9:0] line, input logic mode, input logic ab,
                          input int ack_lo, input int ack_hi,
                          input int gap_lo, input int gap_hi, input int mid_act);
    int          len;
    int          d;
    int          g;
    int          waited;
    logic [23:0] base;
    logic [23:0] a0;
    len  = mode ? 1024 : 640;
    base = 24'(FB_BASE_TB + int'(line) * len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({ab, 10'(i), mdata(base + 24'(i))});
    end
    vga_mode       = mode;
    read_buff_A_B  = ab;
    read_buff_addr = line;
    read_buff_req  = 1'b1;
    step();
    for (int b = 0; b < len / BL; b++) begin
      waited = 0;
      while (!mem_req && waited < 40) begin
        step();
        waited++;
      end
      if (!mem_req) begin
        chk("req_timeout", 64'(mem_req), 64'd1);
        exp_q.delete();
        read_buff_req = 1'b0;
        step();
        return;
      end
      chk("burst_addr", 64'(mem_addr), 64'(base + 24'(b * BL)));
      a0 = mem_addr;
      if (b == 2 && mid_act == 1) begin
        vga_mode       = ~mode;
        read_buff_A_B  = ~ab;
        read_buff_addr = line ^ 10'h155;
        read_buff_req  = 1'b0;
      end
      if (b == 2 && mid_act == 2) begin
        read_buff_req = 1'b0;
        step();
        read_buff_req = 1'b1;
        step();
        chk("underrun_set", 64'(underrun), 64'd1);
        read_buff_req = 1'b0;
        step();
        read_buff_req = 1'b1;
        clear_err     = 1'b1;
        step();
        clear_err     = 1'b0;
        chk("underrun_set_wins", 64'(underrun), 64'd1);
      end
      d = $urandom_range(ack_hi, ack_lo);
      repeat (d) begin
        step();
        chk("req_hold", 64'(mem_req), 64'd1);
        chk("addr_hold", 64'(mem_addr), 64'(a0));
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("req_drop", 64'(mem_req), 64'd0);
      for (int k = 0; k < BL; k++) begin
        g = $urandom_range(gap_hi, gap_lo);
        repeat (g) step();
        mem_rvalid = 1'b1;
        mem_rdata  = mdata(base + 24'(b * BL + k));
        step();
        mem_rvalid = 1'b0;
        if (mid_act == 3 && b == 2 && k == 4) begin
          rst_n_w       = 1'b0;
          read_buff_req = 1'b0;
          #1;
          chk("rst_outs", outs_all, 64'd0);
          exp_q.delete();
          step();
          rst_n_w = 1'b1;
          step();
          repeat (5) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'($urandom);
            step();
          end
          mem_rvalid = 1'b0;
          repeat (3) step();
          chk("rst_busy", 64'(fetch_busy), 64'd0);
          chk("rst_req", 64'(mem_req), 64'd0);
          return;
        end
      end
    end
    read_buff_req = 1'b0;
    repeat (3) step();
    chk("busy_done", 64'(fetch_busy), 64'd0);
    chk("writes_left", 64'(exp_q.size()), 64'd0);
    chk("no_req_idle", 64'(mem_req), 64'd0);
  endtask

  // rvalid pulses and mode toggles while idle; the monitor flags any write.
  task automatic stray(input int n);
    repeat (n) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 16'($urandom);
      vga_mode   = ~vga_mode;
      step();
      mem_rvalid = 1'b0;
      step();
    end
    chk("stray_busy", 64'(fetch_busy), 64'd0);
  endtask

  initial begin
    rst_n_w        = 1'b0;
    vga_mode       = 1'b0;
    read_buff_req  = 1'b0;
    read_buff_A_B  = 1'b0;
    read_buff_addr = 10'd0;
    clear_err      = 1'b0;
    mem_ack        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = 16'd0;
    repeat (3) step();
    chk("reset_outs", outs_all, 64'd0);
    rst_n_w = 1'b1;
    step();

    // mode 0, line 5, buffer A, immediate ack, back-to-back beats
    do_fetch(10'd5, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    // mode 1, last line 767 of 768, buffer B
    do_fetch(10'd767, 1'b1, 1'b1, 0, 0, 0, 0, 0);
    // ack after 7 cycles, beats every other cycle
    do_fetch(10'd100, 1'b0, 1'b1, 7, 7, 1, 1, 0);
    // request during a fetch
    do_fetch(10'd3, 1'b1, 1'b0, 0, 2, 0, 1, 2);
    chk("underrun_kept", 64'(underrun), 64'd1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("underrun_clear", 64'(underrun), 64'd0);
    // reset mid-burst, then a normal fetch
    do_fetch(10'd200, 1'b0, 1'b0, 0, 1, 0, 1, 3);
    do_fetch(10'd201, 1'b0, 1'b1, 0, 1, 0, 1, 0);
    // idle noise and inputs changed mid-fetch
    stray(6);
    do_fetch(10'd9, 1'b1, 1'b0, 1, 2, 0, 2, 1);
    stray(4);
    chk("underrun_quiet", 64'(underrun), 64'd0);
    // randomized fetches
    for (int r = 0; r < 5; r++) begin
      do_fetch(10'($urandom_range(1023, 0)), 1'($urandom), 1'($urandom),
               0, 4, 0, 2, 0);
      if ($urandom_range(1, 0) == 1) stray(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_line_fetch.md
VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 SHALL have parameter FB_BASE, default 24'h000000, meaning word address of the framebuffer's line 0.
REQ-002 SHALL have parameter BURST_LEN, default 16, meaning words per memory burst (power of two, 4..64; divides 640 and 1024).
REQ-003 SHALL have port vga_clk  input  1  pixel clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_w  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port vga_mode  input  1  0=640 words/line, 1=1024 words/line.
REQ-006 SHALL have port read_buff_req  input  1  line-fetch request level from the VGA timing generator.
REQ-007 SHALL have port read_buff_A_B  input  1  target line buffer: 0=A, 1=B.
REQ-008 SHALL have port read_buff_addr  input  10  line number to fetch.
REQ-009 SHALL have port clear_err  input  1  clears underrun.
REQ-010 SHALL have port mem_req  output  1  burst read request.
REQ-011 SHALL have port mem_addr  output  24  burst start word address.
REQ-012 SHALL have port mem_ack  input  1  one-cycle burst acceptance.
REQ-013 SHALL have port mem_rvalid  input  1  read-data beat valid.
REQ-014 SHALL have port mem_rdata  input  16  read-data beat.
REQ-015 SHALL have ports buffA_wr_en/buffB_wr_en  output  1 each  line-buffer write strobes.
REQ-016 SHALL have port buff_wr_addr  output  10  shared line-buffer write address.
REQ-017 SHALL have port buff_wr_data  output  16  shared line-buffer write data.
REQ-018 SHALL have port fetch_busy  output  1  high while a line fetch is in progress.
REQ-019 SHALL have port underrun  output  1  sticky error flag.

Function
REQ-020 SHALL register read_buff_req once and detect its rising edge (req_rise) in the following cycle.
REQ-021 SHALL implement the FSM states IDLE, ISSUE, DATA.
REQ-022 In IDLE, on req_rise, SHALL latch line, buffer select and vga_mode, clear word_idx (11 bits) to 0, set fetch_busy=1 and enter ISSUE.
REQ-023 SHALL compute the line base as FB_BASE + line*1024 (line<<10) in mode 1, or FB_BASE + (line<<9) + (line<<7) in mode 0; no multiplier; result truncated to 24 bits.
REQ-024 In ISSUE, SHALL hold mem_req=1 and mem_addr=line_base+word_idx stable until the cycle mem_ack=1, then drop mem_req in the next cycle and enter DATA.
REQ-025 In DATA, each mem_rvalid beat SHALL assert exactly one of buffA_wr_en/buffB_wr_en (selected by latched A_B) for one cycle, with buff_wr_addr=word_idx[9:0] and buff_wr_data=mem_rdata, and then increment word_idx.
REQ-026 After BURST_LEN beats, SHALL return to IDLE with fetch_busy=0 if word_idx equals the latched line length (640/1024), else to ISSUE.
REQ-027 Write outputs SHALL be registered: 1-cycle latency from mem_rvalid to write strobe.
REQ-028 mem_rvalid outside DATA SHALL be ignored (no write, no count change).
REQ-029 req_rise while not IDLE SHALL set underrun=1 and be dropped; the current fetch SHALL continue unaffected.
REQ-030 Deassertion of read_buff_req mid-fetch SHALL NOT abort the fetch.
REQ-031 vga_mode changes mid-fetch SHALL NOT affect the fetch in progress (latched value used).
REQ-032 clear_err=1 SHALL clear underrun next cycle; simultaneous set and clear SHALL leave underrun=1.
REQ-033 Write strobes SHALL never both be high in the same cycle.

Reset
REQ-034 On rst_n_w=0, SHALL force state IDLE and drive mem_req, mem_addr, buffA_wr_en, buffB_wr_en, buff_wr_addr, buff_wr_data, fetch_busy, underrun and word_idx to 0 immediately; reset mid-burst SHALL abandon the fetch, and later beats SHALL be ignored per REQ-028.

Verification
REQ-035 Mode 0, line 5, A_B=0, req rise, immediate ack, back-to-back rvalid -> 40 bursts at mem_addr 3200,3216,...,3824; 640 buffA writes at addr 0..639; buffB never written; fetch_busy drops after the last write.
REQ-036 Mode 1, line 767, A_B=1 -> first mem_addr 785408; 1024 buffB writes; buff_wr_addr wraps 1023 -> done.
REQ-037 mem_ack delayed 7 cycles and rvalid gapped every other cycle -> mem_req and mem_addr stay stable until ack; data and order are intact.
REQ-038 Second req rise during a fetch -> underrun=1, the first fetch completes at full length; clear_err -> underrun=0.
REQ-039 rst_n_w pulsed low mid-DATA -> all outputs 0 at once; stray rvalid afterwards produces no writes; the next req rise fetches normally.
REQ-040 vga_mode toggled mid-fetch and rvalid injected in IDLE -> line length unchanged and no spurious writes.
